matmul_operand_streamer: RTL and testbench

- Feeds operand pairs to the square-matmul datapath (`data_a`/`data_b`/`valid` stream); it is the producer end of that interface.
- On `start`, it reads N×N row-major matrices A and B from two synchronous-read operand memories.
- It emits N³ beats in (i, j, k) order, k fastest: beat = {A[i][k], B[k][j]}, with markers for end-of-dot-product and end-of-matrix.
- Supports downstream backpressure via `ready_in` at full throughput.

---
 rtl/matmul_pkg.sv | 15 +
 rtl/matmul_beat_fifo.sv | 48 ++++
 rtl/matmul_operand_streamer.sv | 144 ++++++++++++++
 tb/tb_matmul_operand_streamer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared types and helpers for the square-matmul operand and result streaming blocks.
package matmul_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} stream_state_t;

  typedef struct packed {
    logic last_k;
    logic last;
  } beat_tag_t;

  function automatic int rowmajor_addr(input int row, input int col, input int n);
    return row * n + col;
  endfunction

endpackage

// File: rtl/matmul_beat_fifo.sv
// Two-entry beat buffer; slot0 is always the head so outputs come straight from a flop.
module matmul_beat_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] slot0_q, slot0_d, slot1_q, slot1_d;
  logic [1:0]   count_q, count_d, wr_idx;
  logic         pop_ok;

  assign pop_ok = pop && (count_q != 2'd0);

  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    wr_idx  = count_q - {1'b0, pop_ok};
    count_d = count_q + {1'b0, push} - {1'b0, pop_ok};
    if (pop_ok) slot0_d = slot1_q;
    // Write position accounts for the shift caused by a same-cycle pop.
    if (push) begin
      if (wr_idx == 2'd0) slot0_d = push_data;
      else                slot1_d = push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

  assign head  = slot0_q;
  assign count = count_q;

endmodule

// File: rtl/matmul_operand_streamer.sv
// Streams {A[i][k], B[k][j]} operand beats in (i, j, k) order from two synchronous-read memories.
module matmul_operand_streamer
  import matmul_pkg::*;
#(
  parameter int  N      = 4,
  parameter int  DATA_W = 32,
  localparam int ADDR_W = $clog2(N * N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_a_addr,
  output logic [ADDR_W-1:0] mem_b_addr,
  input  logic [DATA_W-1:0] mem_a_rdata,
  input  logic [DATA_W-1:0] mem_b_rdata,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] data_b,
  output logic              last_k,
  output logic              last
);

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    beat_tag_t         tag;
  } operand_beat_t;

  localparam int             CNT_W    = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  stream_state_t    state_q, state_d;
  logic [CNT_W-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
  beat_tag_t        tag_q, tag_d;
  logic             inflight_q, inflight_d;
  logic             done_q, done_d;
  logic [ADDR_W-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d;

  logic [1:0]    fifo_count;
  operand_beat_t head, push_beat;
  logic          pop, rd_en, last_issue;

  assign valid_out  = (fifo_count != 2'd0);
  assign pop        = valid_out && ready_in;
  // Occupancy after this cycle's pop plus the read already in flight must leave a free slot.
  assign rd_en      = (state_q == RUN) &&
                      (({1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop}) < 3'd2);
  assign last_issue = (i_q == LAST_IDX) && (j_q == LAST_IDX) && (k_q == LAST_IDX);

  assign addr_a_d   = rd_en ? ADDR_W'(rowmajor_addr(32'(i_q), 32'(k_q), N)) : addr_a_q;
  assign addr_b_d   = rd_en ? ADDR_W'(rowmajor_addr(32'(k_q), 32'(j_q), N)) : addr_b_q;
  assign inflight_d = rd_en;

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    tag_d   = tag_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
        end
      end
      RUN: begin
        if (rd_en) begin
          tag_d.last_k = (k_q == LAST_IDX);
          tag_d.last   = last_issue;
          k_d          = (k_q == LAST_IDX) ? '0 : k_q + ONE;
          if (k_q == LAST_IDX) begin
            j_d = (j_q == LAST_IDX) ? '0 : j_q + ONE;
            if (j_q == LAST_IDX) i_d = (i_q == LAST_IDX) ? '0 : i_q + ONE;
          end
          if (last_issue) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!inflight_q && ((fifo_count - {1'b0, pop}) == 2'd0)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      i_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
      tag_q      <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      addr_a_q   <= '0;
      addr_b_q   <= '0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      k_q        <= k_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
      addr_a_q   <= addr_a_d;
      addr_b_q   <= addr_b_d;
    end
  end

  // Read data arrives one cycle after issue, paired with the tag captured at issue.
  assign push_beat = '{a: mem_a_rdata, b: mem_b_rdata, tag: tag_q};

  matmul_beat_fifo #(.W($bits(operand_beat_t))) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data (push_beat),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count)
  );

  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign mem_rd_en  = rd_en;
  assign mem_a_addr = addr_a_d;
  assign mem_b_addr = addr_b_d;
  assign data_a     = head.a;
  assign data_b     = head.b;
  assign last_k     = head.tag.last_k;
  assign last       = head.tag.last;

endmodule

// File: tb/tb_matmul_operand_streamer.sv
// Bench for matmul_operand_streamer: N=2 scenarios with a scoreboard, plus an N=4 address/beat run.
module tb_matmul_operand_streamer;

  localparam int DW = 32;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          lk;
    logic          l;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // N=2 instance signals
  logic          start2, busy2, done2, rd2, valid2, ready2, lk2, l2;
  logic [1:0]    aa2, ba2;
  logic [DW-1:0] ra2, rb2, da2, db2;
  // N=4 instance signals
  logic          start4, busy4, done4, rd4, valid4, ready4, lk4, l4;
  logic [3:0]    aa4, ba4;
  logic [DW-1:0] ra4, rb4, da4, db4;

  logic [DW-1:0] mA2 [4];
  logic [DW-1:0] mB2 [4];
  logic [DW-1:0] mA4 [16];
  logic [DW-1:0] mB4 [16];

  matmul_operand_streamer #(.N(2), .DATA_W(DW)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
    .mem_rd_en(rd2), .mem_a_addr(aa2), .mem_b_addr(ba2),
    .mem_a_rdata(ra2), .mem_b_rdata(rb2), .valid_out(valid2), .ready_in(ready2),
    .data_a(da2), .data_b(db2), .last_k(lk2), .last(l2)
  );

  matmul_operand_streamer #(.N(4), .DATA_W(DW)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .busy(busy4), .done(done4),
    .mem_rd_en(rd4), .mem_a_addr(aa4), .mem_b_addr(ba4),
    .mem_a_rdata(ra4), .mem_b_rdata(rb4), .valid_out(valid4), .ready_in(ready4),
    .data_a(da4), .data_b(db4), .last_k(lk4), .last(l4)
  );

  always @(posedge clk) begin
    if (rd2) begin ra2 <= mA2[aa2]; rb2 <= mB2[ba2]; end
    if (rd4) begin ra4 <= mA4[aa4]; rb4 <= mB4[ba4]; end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input bit ok, input string nm, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    chk(act == exp, nm, 66'(act), 66'(exp));
  endtask

  function automatic beat_t mk(input int a, input int b, input bit lk, input bit l);
    beat_t r;
    r.a = DW'(a); r.b = DW'(b); r.lk = lk; r.l = l;
    return r;
  endfunction

  beat_t tbl [8];
  beat_t q2[$];
  beat_t q4[$];
  int    dots[$];

  int s = 0;
  int ready_mode = 0;
  int rrel;
  int rd_cnt, first_rd, first_valid, done_cnt, done_rel, beats, acc;
  bit p_valid, p_ready, p_rd;
  beat_t p_beat, cur2, cur4, e2, e4;
  int rd4_cnt, beats4, done4_cnt;

  task automatic clear_stats();
    rd_cnt = 0; first_rd = -1; first_valid = -1; done_cnt = 0; done_rel = -1;
    beats = 0; acc = 0; dots.delete();
    p_valid = 0; p_ready = 0; p_rd = 0; p_beat = '0;
  endtask

  // Ready pattern for the N=2 instance, changed just after each rising edge.
  initial forever begin
    @(posedge clk); #1;
    rrel = cyc - s;
    case (ready_mode)
      1:       ready2 = (rrel < 0) ? 1'b1 : ((rrel % 4 == 0) || (rrel % 4 == 3));
      2:       ready2 = !((rrel >= 1) && (rrel <= 20));
      default: ready2 = 1'b1;
    endcase
  end

  always @(negedge clk) begin
    if (!rst) begin
      cur2 = {da2, db2, lk2, l2};
      if (rd2 && first_rd < 0) first_rd = cyc - s;
      if (rd2) rd_cnt++;
      if (valid2 && first_valid < 0) first_valid = cyc - s;
      if (done2) begin done_cnt++; done_rel = cyc - s; end
      if (p_valid && !p_ready)
        chk(valid2 && (cur2 == p_beat), "hold_while_stalled", cur2, p_beat);
      if (p_rd && p_valid && !p_ready && !ready2)
        chk(!rd2, "read_stops_on_stall", 66'(rd2), 66'(0));
      if (valid2 && ready2) begin
        if (q2.size() == 0) chk(1'b0, "unexpected_beat", cur2, 66'(0));
        else begin
          e2 = q2.pop_front();
          chk(cur2 == e2, "beat_n2", cur2, e2);
        end
        beats++;
        acc += int'(da2) * int'(db2);
        if (lk2) begin dots.push_back(acc); acc = 0; end
      end
      p_valid = valid2; p_ready = ready2; p_rd = rd2; p_beat = cur2;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (rd4) begin
        chk(aa4 == 4'((rd4_cnt / 16) * 4 + rd4_cnt % 4), "addr_a_n4", 66'(aa4),
            66'((rd4_cnt / 16) * 4 + rd4_cnt % 4));
        chk(ba4 == 4'((rd4_cnt % 4) * 4 + (rd4_cnt / 4) % 4), "addr_b_n4", 66'(ba4),
            66'((rd4_cnt % 4) * 4 + (rd4_cnt / 4) % 4));
        rd4_cnt++;
      end
      if (done4) done4_cnt++;
      if (valid4 && ready4) begin
        cur4 = {da4, db4, lk4, l4};
        if (q4.size() == 0) chk(1'b0, "unexpected_beat_n4", cur4, 66'(0));
        else begin
          e4 = q4.pop_front();
          chk(cur4 == e4, "beat_n4", cur4, e4);
        end
        beats4++;
      end
    end
  end

  task automatic start_n2(input bit push_exp);
    @(negedge clk); #1;
    clear_stats();
    s = cyc;
    start2 = 1'b1;
    if (push_exp) foreach (tbl[n]) q2.push_back(tbl[n]);
    @(negedge clk); #1;
    start2 = 1'b0;
  endtask

  task automatic wait_done(input bit wide, input int budget);
    int d0;
    int n;
    d0 = wide ? done4_cnt : done_cnt;
    n = 0;
    while (((wide ? done4_cnt : done_cnt) == d0) && (n < budget)) begin
      @(negedge clk); #1;
      n++;
    end
    chk((wide ? done4_cnt : done_cnt) != d0, "done_within_budget", 66'(n), 66'(budget));
  endtask

  task automatic check_full_run(input string tag);
    repeat (3) @(negedge clk);
    #1;
    chk_int({tag, "_beats"}, beats, 8);
    chk_int({tag, "_reads"}, rd_cnt, 8);
    chk_int({tag, "_done_pulses"}, done_cnt, 1);
    chk_int({tag, "_queue_left"}, q2.size(), 0);
  endtask

  int exp_dot [4];

  initial begin
    tbl[0] = mk(1, 5, 0, 0); tbl[1] = mk(2, 7, 1, 0);
    tbl[2] = mk(1, 6, 0, 0); tbl[3] = mk(2, 8, 1, 0);
    tbl[4] = mk(3, 5, 0, 0); tbl[5] = mk(4, 7, 1, 0);
    tbl[6] = mk(3, 6, 0, 0); tbl[7] = mk(4, 8, 1, 1);
    exp_dot = '{19, 22, 43, 50};
    mA2 = '{32'd1, 32'd2, 32'd3, 32'd4};
    mB2 = '{32'd5, 32'd6, 32'd7, 32'd8};
    for (int n = 0; n < 16; n++) begin
      mA4[n] = ((n / 4) == (n % 4)) ? 32'd1 : 32'd0;
      mB4[n] = $urandom;
    end
    rst = 1'b1; start2 = 1'b0; start4 = 1'b0; ready2 = 1'b1; ready4 = 1'b1;
    rd4_cnt = 0; beats4 = 0; done4_cnt = 0;
    clear_stats();
    repeat (3) @(negedge clk);
    chk({busy2, done2, rd2, valid2} == 4'b0, "reset_control", 66'({busy2, done2, rd2, valid2}), 66'(0));
    chk({lk2, l2, da2, db2} == '0, "reset_data", 66'({da2, db2, lk2, l2}), 66'(0));
    chk({aa2, ba2} == 4'b0, "reset_addr", 66'({aa2, ba2}), 66'(0));
    #1 rst = 1'b0;

    // Full-rate stream with latency and dot-product checks
    ready_mode = 0;
    start_n2(1);
    wait_done(1'b0, 60);
    check_full_run("full_rate");
    chk_int("first_read_cycle", first_rd, 1);
    chk_int("first_valid_cycle", first_valid, 3);
    chk_int("done_cycle", done_rel, 11);
    chk_int("dot_count", dots.size(), 4);
    for (int n = 0; n < 4; n++)
      if (n < dots.size()) chk_int("dot_product", dots[n], exp_dot[n]);

    // Toggling backpressure 1,0,0,1
    ready_mode = 1;
    start_n2(1);
    wait_done(1'b0, 100);
    check_full_run("toggle");

    // Long stall from cycle 1 to 20
    ready_mode = 2;
    start_n2(1);
    while (cyc - s < 20) @(negedge clk);
    #1;
    chk_int("stall_reads", rd_cnt, 2);
    chk(valid2 && ({da2, db2, lk2, l2} == tbl[0]), "stall_head", {da2, db2, lk2, l2}, tbl[0]);
    wait_done(1'b0, 60);
    check_full_run("long_stall");

    // Second start during RUN is ignored
    ready_mode = 0;
    start_n2(1);
    while (cyc - s < 5) @(negedge clk);
    #1 start2 = 1'b1;
    @(negedge clk); #1 start2 = 1'b0;
    wait_done(1'b0, 60);
    repeat (5) @(negedge clk);
    check_full_run("restart_ignored");

    // Asynchronous reset mid-stream, then a fresh run
    start_n2(1);
    while (cyc - s < 5) @(negedge clk);
    @(posedge clk); #2;
    chk(rd2 && busy2 && valid2, "pre_reset_active", 66'({rd2, busy2, valid2}), 66'(7));
    rst = 1'b1;
    #1;
    chk({valid2, busy2, rd2} == 3'b0, "async_reset_abort", 66'({valid2, busy2, rd2}), 66'(0));
    @(negedge clk); @(negedge clk); #1;
    q2.delete();
    rst = 1'b0;
    start_n2(1);
    wait_done(1'b0, 60);
    check_full_run("after_reset");

    // N=4: identity A, random B
    @(negedge clk); #1;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        for (int k = 0; k < 4; k++)
          q4.push_back(mk(int'(mA4[i * 4 + k]), int'(mB4[k * 4 + j]), k == 3,
                          (i == 3) && (j == 3) && (k == 3)));
    start4 = 1'b1;
    @(negedge clk); #1 start4 = 1'b0;
    wait_done(1'b1, 200);
    repeat (3) @(negedge clk);
    #1;
    chk_int("n4_beats", beats4, 64);
    chk_int("n4_reads", rd4_cnt, 64);
    chk_int("n4_queue_left", q4.size(), 0);
    chk_int("n4_done_pulses", done4_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
